// File: rtl/clk_sel_ctrl_pkg.sv
// Shared definitions for the clock-source select sequencer: state encodings,
// source indices and the index-to-select mapping.
package clk_sel_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_LOW = 3'd1,
        ST_GATE     = 3'd2,
        ST_SWITCH   = 3'd3,
        ST_SETTLE   = 3'd4
    } state_e;

    localparam logic [1:0] SRC_SLOW   = 2'd0;
    localparam logic [1:0] SRC_NORMAL = 2'd1;
    localparam logic [1:0] SRC_FAST   = 2'd2;
    localparam logic [1:0] SRC_TURBO  = 2'd3;

    // Returns {sel0, sel1}: sel0 carries index bit 1, sel1 carries index bit 0.
    function automatic logic [1:0] src_to_sel(input logic [1:0] idx);
        return {idx[1], idx[0]};
    endfunction

    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/clk_sel_ctrl_sync_2ff.sv
// Two-flop synchronizer, reset to 0; output lags input by 2 clk cycles.
// No handshake; samples every cycle.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/clk_sel_ctrl.sv
// Glitch-free clock-source select sequencer: waits for the source to be low, gates, switches, settles.
// Latency 2*SETTLE_CYCLES+2 cycles plus wait time; req_ready is low (no queueing) while busy.
module clk_sel_ctrl
    import clk_sel_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned TIMEOUT       = 1023,
    parameter logic [1:0]  DEFAULT_SEL   = 2'b00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_sel,
    output logic       req_ready,
    input  logic       mux_out,
    output logic       sel0,
    output logic       sel1,
    output logic       clk_en,
    output logic       busy,
    output logic       done,
    output logic       timeout_flag
);

    localparam int unsigned CW      = cnt_width(TIMEOUT, SETTLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] ST_LAST = CW'(SETTLE_CYCLES - 1);

    state_e        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [1:0]    tgt_q, tgt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tflag_q, tflag_d;
    logic          done_q, done_d;
    logic          same_q, same_d;
    logic [CW-1:0] cnt_inc;
    logic          mux_sync;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (mux_out),
        .q   (mux_sync)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        tflag_d = tflag_q;
        done_d  = same_q;
        same_d  = 1'b0;
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    tflag_d = 1'b0;
                    if (req_sel == idx_q) begin
                        // Same source: acknowledge one cycle later, no gating.
                        same_d = 1'b1;
                    end else begin
                        tgt_d   = req_sel;
                        cnt_d   = '0;
                        state_d = ST_WAIT_LOW;
                    end
                end
            end
            ST_WAIT_LOW: begin
                if (!mux_sync) begin
                    cnt_d   = '0;
                    state_d = ST_GATE;
                end else if (cnt_q >= TO_LAST) begin
                    cnt_d   = '0;
                    tflag_d = 1'b1;
                    state_d = ST_GATE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_GATE: begin
                if (cnt_q >= ST_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SWITCH;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_SWITCH: begin
                idx_d   = tgt_q;
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q >= ST_LAST) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= DEFAULT_SEL;
            tgt_q   <= DEFAULT_SEL;
            cnt_q   <= '0;
            tflag_q <= 1'b0;
            done_q  <= 1'b0;
            same_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            tflag_q <= tflag_d;
            done_q  <= done_d;
            same_q  <= same_d;
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign clk_en       = (state_q == ST_IDLE) || (state_q == ST_WAIT_LOW);
    assign {sel0, sel1} = src_to_sel(idx_q);
    assign done         = done_q;
    assign timeout_flag = tflag_q;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Bench for clk_sel_ctrl: directed requests, expected completions queued and
// checked by an independent done monitor.
module tb_clk_sel_ctrl;

    localparam int S  = 4;
    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_sel = 2'b00;
    logic       mux_out = 1'b0;
    logic       req_ready, sel0, sel1, clk_en, busy, done, timeout_flag;

    clk_sel_ctrl #(.SETTLE_CYCLES(S), .TIMEOUT(TO), .DEFAULT_SEL(2'b00)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_sel      (req_sel),
        .req_ready    (req_ready),
        .mux_out      (mux_out),
        .sel0         (sel0),
        .sel1         (sel1),
        .clk_en       (clk_en),
        .busy         (busy),
        .done         (done),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [1:0] sel;
        logic       tf;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Completion monitor
    exp_t e;
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done at cyc %0d: got done=1 expected none", cyc);
            end else begin
                e = sb.pop_front();
                if (e.c >= 0) chk("done_cycle", cyc, e.c);
                chk("done_sel", {sel0, sel1}, e.sel);
                chk("done_tflag", timeout_flag, e.tf);
            end
        end
    end

    // Gate-fall monitor used by the square-wave test
    logic       sq_on = 1'b0;
    logic       clk_en_prev = 1'b1;
    logic [3:0] hist = 4'hF;
    int         falls = 0;
    always @(negedge clk) begin
        if (sq_on && clk_en_prev && !clk_en) begin
            falls++;
            chk("fall_after_low", hist[2], 0);
        end
        hist        = {hist[2:0], mux_out};
        clk_en_prev = clk_en;
    end

    int ph = 0;
    initial begin
        forever begin
            @(posedge clk);
            if (sq_on) begin
                ph++;
                if (ph == 5) begin
                    ph = 0;
                    #2 mux_out = ~mux_out;
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout at cyc %0d: got req_ready=0 expected 1", cyc);
        end
    endtask

    task automatic issue(input logic [1:0] idx, input int off, input logic [1:0] esel,
                         input logic etf, output int k);
        exp_t x;
        wait_ready();
        req_valid = 1'b1;
        req_sel   = idx;
        k         = cyc + 1;
        x.c       = (off < 0) ? -1 : k + off;
        x.sel     = esel;
        x.tf      = etf;
        sb.push_back(x);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout at cyc %0d: got %0d pending expected 0", cyc, sb.size());
            sb.delete();
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sel"}, {sel0, sel1}, 2'b00);
        chk({tag, "_clk_en"}, clk_en, 1);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_tflag"}, timeout_flag, 0);
    endtask

    int k;
    int n;

    initial begin
        // Reset release
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst_release");

        // Normal switch to index 2 with mux_out low
        issue(2'd2, 2 * S + 2, 2'b10, 1'b0, k);
        for (int j = 0; j <= 12; j++) begin
            @(negedge clk);
            chk("t1_clk_en", clk_en, (j >= 1 && j <= 2 * S + 1) ? 0 : 1);
            chk("t1_req_ready", req_ready, (j <= 2 * S + 1) ? 0 : 1);
            chk("t1_sel", {sel0, sel1}, (j >= S + 2) ? 2'b10 : 2'b00);
        end
        wait_drain();

        // Same-index request
        issue(2'd2, 1, 2'b10, 1'b0, k);
        for (int j = 0; j <= 4; j++) begin
            @(negedge clk);
            chk("t2_clk_en", clk_en, 1);
            chk("t2_busy", busy, 0);
            chk("t2_sel", {sel0, sel1}, 2'b10);
        end
        wait_drain();

        // Square-wave source, request issued while it is high
        falls = 0;
        ph    = 0;
        sq_on = 1'b1;
        for (int r = 0; r < 2; r++) begin
            n = 0;
            while (mux_out !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            issue((r == 0) ? 2'd1 : 2'd0, -1, (r == 0) ? 2'b01 : 2'b00, 1'b0, k);
            wait_drain();
        end
        sq_on = 1'b0;
        chk("t3_gate_falls", falls, 2);
        mux_out = 1'b0;
        repeat (4) @(negedge clk);

        // Stuck-high source forces a timeout switch to index 3
        mux_out = 1'b1;
        repeat (4) @(negedge clk);
        issue(2'd3, TO + 2 * S + 1, 2'b11, 1'b1, k);
        for (int j = 0; j <= TO; j++) begin
            @(negedge clk);
            if (j == TO - 1) chk("t4_clk_en_last_wait", clk_en, 1);
            if (j == TO)     chk("t4_clk_en_gated", clk_en, 0);
        end
        wait_drain();
        @(negedge clk);
        chk("t4_tflag_sticky", timeout_flag, 1);
        mux_out = 1'b0;
        repeat (4) @(negedge clk);
        issue(2'd0, 2 * S + 2, 2'b00, 1'b0, k);
        @(negedge clk);
        chk("t4_tflag_cleared", timeout_flag, 0);
        wait_drain();

        // Reset pulsed during SETTLE
        issue(2'd2, 2 * S + 2, 2'b10, 1'b0, k);
        for (int j = 0; j <= S + 3; j++) @(negedge clk);
        chk("t5_sel_before_rst", {sel0, sel1}, 2'b10);
        rst = 1'b1;
        sb.delete();
        #1;
        chk_reset_vals("t5_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("t5_sel_after_rst", {sel0, sel1}, 2'b00);
        issue(2'd1, 2 * S + 2, 2'b01, 1'b0, k);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
